// File: rtl/fpu_md_pkg.sv
// Shared definitions for the FP multiply/divide significand path.
// Holds the significand/exponent widths, the divider FSM state type and the
// sign/exponent sidecar bundle passed from signexpmd through to the rounder.
package fpu_md_pkg;

    localparam int P  = 53;          // significand width including hidden bit
    localparam int EW = 13;          // sidecar exponent width
    localparam int QW = P + 2;       // quotient bits: 1 integer + P+1 fraction
    localparam int CW = $clog2(QW);  // iteration counter width

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } md_state_t;

    typedef struct packed {
        logic          sq;
        logic [EW-1:0] eq;
    } md_side_t;

endpackage

// File: rtl/sigdiv_step.sv
// One restoring radix-2 division iteration (purely combinational).
// Ports:
//   r      partial remainder, P+1 bits (always < 2*d on entry)
//   d      normalized divisor, P bits
//   qbit   quotient bit for this iteration (r >= d)
//   r_next remainder after conditional subtract, shifted left by one
module sigdiv_step #(
    parameter int P = 53
) (
    input  logic [P:0]   r,
    input  logic [P-1:0] d,
    output logic         qbit,
    output logic [P:0]   r_next
);

    logic [P:0] diff;
    logic [P:0] r_sel;

    always_comb begin
        diff   = r - {1'b0, d};
        qbit   = (r >= {1'b0, d});
        r_sel  = qbit ? diff : r;
        // r_sel < d < 2^P, so the msb is zero and the shift cannot overflow
        r_next = r_sel << 1;
    end

endmodule

// File: rtl/sigdiv_iter.sv
// Iterative radix-2 restoring significand divider for the FP divide path.
// Takes normalized significands plus the sign/exponent sidecar from signexpmd
// and delivers {quotient, sticky} with the sidecar aligned for the rounder.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous abort back to IDLE
//   in_valid/in_ready     operand handshake (fa, fb, sq_in, eq_in)
//   out_valid/out_ready   result handshake (fq, sq_out, eq_out, dbz)
//   fq                    {quotient[QW-1:0], sticky}; quotient[QW-1] is the integer bit
//   dbz                   divisor msb was zero; fq forced to 0
module sigdiv_iter
    import fpu_md_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [P-1:0]  fa,
    input  logic [P-1:0]  fb,
    input  logic          sq_in,
    input  logic [EW-1:0] eq_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW:0]   fq,
    output logic          sq_out,
    output logic [EW-1:0] eq_out,
    output logic          dbz
);

    md_state_t     state;
    md_side_t      side;
    logic [P:0]    r;
    logic [P-1:0]  d;
    logic [QW-1:0] q;
    logic [CW-1:0] cnt;

    logic          qbit;
    logic [P:0]    r_next;
    logic [QW-1:0] q_next;

    sigdiv_step #(.P(P)) u_step (
        .r      (r),
        .d      (d),
        .qbit   (qbit),
        .r_next (r_next)
    );

    always_comb begin
        q_next = (q << 1) | QW'(qbit);
    end

    assign sq_out = side.sq;
    assign eq_out = side.eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            fq        <= '0;
            side      <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            r         <= '0;
            d         <= '0;
            q         <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dbz       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        side     <= '{sq: sq_in, eq: eq_in};
                        in_ready <= 1'b0;
                        if (fb[P-1]) begin
                            r     <= {1'b0, fa};
                            d     <= fb;
                            q     <= '0;
                            cnt   <= CW'(QW - 1);
                            dbz   <= 1'b0;
                            state <= RUN;
                        end else begin
                            fq        <= '0;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        fq        <= {q_next, |r_next};
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigdiv_iter.sv
// Testbench for sigdiv_iter: scoreboard of expected results computed with
// a wide integer division reference, one task per scenario.
module tb_sigdiv_iter;
    import fpu_md_pkg::*;

    localparam int NW = P + QW - 1;
    localparam logic [P-1:0] ONE  = 53'h10_0000_0000_0000;
    localparam logic [P-1:0] ONE5 = 53'h18_0000_0000_0000;

    typedef struct {
        logic [QW:0]   fq;
        logic          sq;
        logic [EW-1:0] eq;
        logic          dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [P-1:0]  fa;
    logic [P-1:0]  fb;
    logic          sq_in;
    logic [EW-1:0] eq_in;
    logic          out_valid;
    logic          out_ready;
    logic [QW:0]   fq;
    logic          sq_out;
    logic [EW-1:0] eq_out;
    logic          dbz;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    sigdiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fa        (fa),
        .fb        (fb),
        .sq_in     (sq_in),
        .eq_in     (eq_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fq        (fq),
        .sq_out    (sq_out),
        .eq_out    (eq_out),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    // Reference: q = floor(a * 2^(QW-1) / b), sticky = remainder != 0
    function automatic logic [QW:0] model_fq(input logic [P-1:0] a, input logic [P-1:0] b);
        logic [NW-1:0] num;
        logic [NW-1:0] den;
        logic [NW-1:0] quo;
        logic [NW-1:0] rem;
        num = {a, {(QW-1){1'b0}}};
        den = NW'(b);
        quo = num / den;
        rem = num % den;
        return {quo[QW-1:0], (rem != '0)};
    endfunction

    task automatic send(input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic s, input logic [EW-1:0] e);
        exp_t x;
        int   n;
        fa = a; fb = b; sq_in = s; eq_in = e; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x.fq  = b[P-1] ? model_fq(a, b) : '0;
        x.sq  = s;
        x.eq  = e;
        x.dbz = ~b[P-1];
        sb.push_back(x);
    endtask

    // Called just after the acceptance edge; latency counts that edge as 1.
    task automatic wait_result(input int exp_lat, input string name, output logic [QW:0] efq);
        int   lat;
        exp_t x;
        lat = 1;
        efq = '0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: unexpected output fq=%h", name, fq);
            return;
        end
        x   = sb.pop_front();
        efq = x.fq;
        checks++;
        if (fq !== x.fq) begin
            errors++;
            $display("FAIL %s_fq: got %h required %h", name, fq, x.fq);
        end
        checks++;
        if (sq_out !== x.sq) begin
            errors++;
            $display("FAIL %s_sq: got %b required %b", name, sq_out, x.sq);
        end
        checks++;
        if (eq_out !== x.eq) begin
            errors++;
            $display("FAIL %s_eq: got %h required %h", name, eq_out, x.eq);
        end
        checks++;
        if (dbz !== x.dbz) begin
            errors++;
            $display("FAIL %s_dbz: got %b required %b", name, dbz, x.dbz);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: in_ready=%b required 0", name, in_ready);
        end
    endtask

    // out_ready is high: the result leaves on the next edge.
    task automatic release_result(input string name);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic run_op(input logic [P-1:0] a, input logic [P-1:0] b,
                          input logic s, input logic [EW-1:0] e, input string name);
        logic [QW:0] efq;
        send(a, b, s, e);
        wait_result(b[P-1] ? QW + 1 : 1, name, efq);
        release_result(name);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fa = '0; fb = '0; sq_in = 1'b0; eq_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++;
        if (fq !== '0) begin errors++; $display("FAIL rst_fq: got %h required 0", fq); end
        checks++;
        if (sq_out !== 1'b0 || eq_out !== '0) begin
            errors++; $display("FAIL rst_side: got %b %h required 0 0", sq_out, eq_out);
        end
        checks++;
        if (dbz !== 1'b0) begin errors++; $display("FAIL rst_dbz: got %b required 0", dbz); end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_divide();
        logic [63:0] w;
        logic [P-1:0] a;
        logic [P-1:0] b;
        run_op(ONE, ONE, 1'b1, 13'h03FF, "one_by_one");
        run_op(ONE5, ONE, 1'b0, 13'h0400, "onehalf_by_one");
        run_op(ONE, ONE5, 1'b1, 13'h03FE, "one_by_onehalf");
        run_op('0, ONE5, 1'b0, 13'h0001, "zero_dividend");
        run_op({P{1'b1}}, ONE, 1'b0, 13'h1FFF, "max_by_one");
        run_op(ONE, {P{1'b1}}, 1'b1, 13'h0000, "one_by_max");
        for (int i = 0; i < 4; i++) begin
            w = {$urandom(), $urandom()};
            a = {1'b1, w[P-2:0]};
            w = {$urandom(), $urandom()};
            b = {1'b1, w[P-2:0]};
            run_op(a, b, 1'($urandom()), EW'($urandom()), "random");
        end
    endtask

    task automatic test_dbz();
        run_op(ONE5, '0, 1'b1, 13'h0123, "dbz_zero");
        run_op(ONE5, 53'h0F_FFFF_FFFF_FFFF, 1'b0, 13'h0456, "dbz_denorm");
        run_op(ONE5, ONE5, 1'b0, 13'h0789, "after_dbz");
    endtask

    task automatic test_backpressure();
        logic [QW:0] efq;
        out_ready = 1'b0;
        send(ONE, ONE5, 1'b1, 13'h0AAA);
        wait_result(QW + 1, "bp", efq);
        for (int i = 0; i < 10; i++) begin
            fa = ONE5; fb = ONE; sq_in = 1'b0; eq_in = 13'h0555; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || fq !== efq) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b fq=%h required 1 0 %h",
                         out_valid, in_ready, fq, efq);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        release_result("bp");
    endtask

    task automatic test_flush();
        logic rose;
        rose = 1'b0;
        send(ONE5, ONE5, 1'b0, 13'h0111);
        repeat (19) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) rose = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b dbz=%b required 1 0 0",
                     in_ready, out_valid, dbz);
        end
        repeat (60) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++; $display("FAIL flush_no_output: out_valid rose=%b required 0", rose);
        end
        sb.delete();
        run_op(ONE, ONE, 1'b1, 13'h03FF, "after_flush");
    endtask

    task automatic test_rst_mid();
        send(ONE, ONE5, 1'b1, 13'h0222);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fq !== '0 || sq_out !== 1'b0 ||
            eq_out !== '0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: in_ready=%b out_valid=%b fq=%h sq=%b eq=%h dbz=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, fq, sq_out, eq_out, dbz);
        end
        #2 rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        run_op(ONE, ONE, 1'b1, 13'h03FF, "after_rst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divide();
        test_dbz();
        test_backpressure();
        test_flush();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
